// File: rtl/burst_row_memory.sv
// Burst row memory: bus slave on the shared 8-bit start/dValid bus with a
// one-row buffer in front of a slower array. Writes to a clean row skip the
// write-back. Write beats that arrive while the row is not yet usable are
// queued in a small FIFO and replayed into the row buffer in arrival order.
//
// Slave FSM
//   state     | meaning
//   S_IDLE    | waiting for a start addressed to this page
//   S_ADDR_LO | upper byte latched, waiting for the lower byte
//   S_RD_WAIT | read issued, waiting for the row to become valid
//   S_RD_BEAT | driving read beats
//   S_WR_BEAT | accepting write beats from the master
//
// Row FSM
//   state     | meaning
//   R_INVALID | row buffer holds nothing
//   R_VALID   | row buffer holds row_q; FIFO drains here
//   R_WB      | writing the dirty row buffer back to the array
//   R_FILL    | loading the new row from the array
module burst_row_memory #(
    parameter int                   PAGE_BITS = 2,
    parameter logic [PAGE_BITS-1:0] BASE_ADDR = '0,
    parameter int                   ROW_BYTES = 256,
    parameter int                   NUM_ROWS  = 64,
    parameter int                   BURST_LEN = 4,
    parameter int                   MEM_LAT   = 2
) (
    input  logic        b_Clock,
    input  logic        b_Reset,
    input  logic        b_Start_L,
    input  logic        b_re_L,
    input  logic [7:0]  b_Addr,
    inout  wire  [7:0]  b_Data,
    inout  wire         b_dValid_L,
    output logic        busy,
    output logic [15:0] miss_count
);

    localparam int COL_W = $clog2(ROW_BYTES);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [3:0]       BEAT_LOAD = 4'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR_LO, S_RD_WAIT, S_RD_BEAT, S_WR_BEAT} slv_t;
    typedef enum logic [1:0] {R_INVALID, R_VALID, R_WB, R_FILL} row_t;

    slv_t slv_q, slv_d;
    row_t row_st_q, row_st_d;

    logic [7:0]       upper_q;
    logic             rd_q;
    logic [COL_W-1:0] col_q;
    logic [3:0]       beat_q;
    logic [ROW_W-1:0] row_q, new_row_q;
    logic             dirty_q;
    logic [LAT_W-1:0] lat_q;
    logic [15:0]      miss_q;

    logic [7:0]       mem     [NUM_ROWS][ROW_BYTES];
    logic [7:0]       row_buf [ROW_BYTES];
    logic [COL_W-1:0] fifo_col [BURST_LEN];
    logic [7:0]       fifo_dat [BURST_LEN];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q;

    logic [15:0]      addr_full;
    logic             unused_addr;
    logic [ROW_W-1:0] cmp_row;
    logic page_hit, compare, hit, miss, lat_done, fifo_empty;
    logic wr_beat, direct, push, pop, fill_done, wb_done;
    logic drv_valid, valid_val, drv_data;

    assign addr_full   = {upper_q, b_Addr};
    assign unused_addr = ^addr_full;
    assign cmp_row     = addr_full[COL_W +: ROW_W];
    assign page_hit    = (b_Addr[7 -: PAGE_BITS] == BASE_ADDR);
    assign compare     = (slv_q == S_ADDR_LO) && b_Start_L;
    assign hit         = (row_st_q == R_VALID) && (row_q == cmp_row);
    assign miss        = compare && !hit;
    assign lat_done    = (lat_q == '0);
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign wr_beat     = (slv_q == S_WR_BEAT) && (b_dValid_L == 1'b0);
    assign direct      = wr_beat && (row_st_q == R_VALID) && fifo_empty;
    assign push        = wr_beat && !direct;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Slave state register plus address/beat bookkeeping.
    always_ff @(posedge b_Clock) begin
        if (b_Reset) begin
            slv_q   <= S_IDLE;
            upper_q <= '0;
            rd_q    <= 1'b0;
            col_q   <= '0;
            beat_q  <= '0;
        end else begin
            slv_q <= slv_d;
            if (slv_q == S_IDLE && slv_d == S_ADDR_LO) begin
                upper_q <= b_Addr;
                rd_q    <= !b_re_L;
            end
            if (compare) begin
                col_q  <= addr_full[COL_W-1:0];
                beat_q <= BEAT_LOAD;
            end else if (slv_q == S_RD_BEAT || wr_beat) begin
                col_q  <= col_q + 1'b1;
                beat_q <= beat_q - 1'b1;
            end
        end
    end

    // Slave next state. A new start is held off while queued beats remain,
    // so a following row compare never strands FIFO entries of the old row.
    always_comb begin
        slv_d = slv_q;
        case (slv_q)
            S_IDLE:    if (!b_Start_L && page_hit && fifo_empty) slv_d = S_ADDR_LO;
            S_ADDR_LO: if (b_Start_L) slv_d = rd_q ? S_RD_WAIT : S_WR_BEAT;
            S_RD_WAIT: if (row_st_q == R_VALID) slv_d = S_RD_BEAT;
            S_RD_BEAT: if (beat_q == '0) slv_d = S_IDLE;
            S_WR_BEAT: if (wr_beat && beat_q == '0) slv_d = S_IDLE;
            default:   slv_d = S_IDLE;
        endcase
    end

    // Slave bus-drive decode.
    always_comb begin
        drv_valid = 1'b0;
        valid_val = 1'b1;
        drv_data  = 1'b0;
        case (slv_q)
            S_ADDR_LO: drv_valid = rd_q;
            S_RD_WAIT: drv_valid = 1'b1;
            S_RD_BEAT: begin
                drv_valid = 1'b1;
                valid_val = 1'b0;
                drv_data  = 1'b1;
            end
            default: ;
        endcase
    end

    // Row state register, latency timer, miss counter and dirty flag.
    always_ff @(posedge b_Clock) begin
        if (b_Reset) begin
            row_st_q  <= R_INVALID;
            row_q     <= '0;
            new_row_q <= '0;
            dirty_q   <= 1'b0;
            lat_q     <= '0;
            miss_q    <= '0;
        end else begin
            row_st_q <= row_st_d;
            if (row_st_d != row_st_q) lat_q <= LAT_LOAD;
            else if (!lat_done)       lat_q <= lat_q - 1'b1;
            if (miss) begin
                new_row_q <= cmp_row;
                if (miss_q != 16'hFFFF) miss_q <= miss_q + 1'b1;
            end
            if (fill_done)            dirty_q <= 1'b0;
            else if (direct || pop)   dirty_q <= 1'b1;
            if (fill_done) row_q <= new_row_q;
        end
    end

    // Row next state.
    always_comb begin
        row_st_d = row_st_q;
        case (row_st_q)
            R_INVALID: if (miss) row_st_d = R_FILL;
            R_VALID:   if (miss) row_st_d = dirty_q ? R_WB : R_FILL;
            R_WB:      if (lat_done) row_st_d = R_FILL;
            R_FILL:    if (lat_done) row_st_d = R_VALID;
            default:   row_st_d = R_INVALID;
        endcase
    end

    // Row FSM outputs: array commit strobes and FIFO drain.
    always_comb begin
        fill_done = (row_st_q == R_FILL) && lat_done;
        wb_done   = (row_st_q == R_WB) && lat_done;
        pop       = (row_st_q == R_VALID) && !fifo_empty;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge b_Clock) begin
        if (b_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage: FIFO slots, row buffer and array; nothing commits on a reset edge.
    always_ff @(posedge b_Clock) begin
        if (!b_Reset) begin
            if (push) begin
                fifo_col[wr_ptr_q] <= col_q;
                fifo_dat[wr_ptr_q] <= b_Data;
            end
            if (fill_done)   row_buf <= mem[new_row_q];
            else if (pop)    row_buf[fifo_col[rd_ptr_q]] <= fifo_dat[rd_ptr_q];
            else if (direct) row_buf[col_q] <= b_Data;
            if (wb_done) mem[row_q] <= row_buf;
        end
    end

    assign b_dValid_L = drv_valid ? valid_val : 1'bz;
    assign b_Data     = drv_data ? row_buf[col_q] : 8'hzz;
    assign busy       = (slv_q != S_IDLE) || !fifo_empty;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_burst_row_memory.sv
// Directed bench for burst_row_memory with default parameters
// (page 0, 256-byte rows, 64 rows, 4-beat bursts, 2-cycle array latency).
module tb_burst_row_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_l, re_l;
    logic [7:0]  addr;
    logic [7:0]  tb_data;
    logic        tb_data_en, tb_dv, tb_dv_en;
    wire  [7:0]  b_data;
    wire         b_dv;
    logic        busy;
    logic [15:0] miss;

    assign b_data = tb_data_en ? tb_data : 8'hzz;
    assign b_dv   = tb_dv_en ? tb_dv : 1'bz;

    burst_row_memory dut (
        .b_Clock    (clk),
        .b_Reset    (rst),
        .b_Start_L  (start_l),
        .b_re_L     (re_l),
        .b_Addr     (addr),
        .b_Data     (b_data),
        .b_dValid_L (b_dv),
        .busy       (busy),
        .miss_count (miss)
    );

    typedef struct {
        bit          rd;
        logic [15:0] a;
        logic [31:0] d;
        int          gap;
        int          exp_lat;
        bit          chk_data;
        int          exp_drain;
        int          exp_miss;
    } vec_t;

    vec_t vecs [14];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a, output int lat, output logic [31:0] got);
        start_l = 1'b0; re_l = 1'b0; addr = a[15:8];
        tick();
        start_l = 1'b1; addr = a[7:0];
        tick();
        lat = 0;
        got = '0;
        while (lat < 40) begin
            tick();
            lat++;
            if (b_dv === 1'b0) break;
        end
        if (b_dv === 1'b0) begin
            got = {got[23:0], b_data};
            for (int i = 1; i < 4; i++) begin
                tick();
                got = {got[23:0], b_data};
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int gap,
                            output int drain);
        start_l = 1'b0; re_l = 1'b1; addr = a[15:8];
        tb_dv = 1'b1; tb_dv_en = 1'b1;
        tick();
        start_l = 1'b1; addr = a[7:0];
        tick();
        for (int i = 0; i < 4; i++) begin
            tb_dv = 1'b0;
            tb_data = d[31-8*i -: 8];
            tb_data_en = 1'b1;
            tick();
            tb_dv = 1'b1;
            repeat (gap) tick();
        end
        tb_dv_en = 1'b0;
        tb_data_en = 1'b0;
        drain = 0;
        while (busy && drain < 40) begin
            tick();
            drain++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, drain;
        logic [31:0] got;

        //          rd    addr      data          gap lat chk drain miss
        vecs[0]  = '{1'b1, 16'h0310, 32'h00000000, 0, 3, 1'b0, 0, 1};
        vecs[1]  = '{1'b0, 16'h0310, 32'hAABBCCDD, 0, 0, 1'b0, 0, 1};
        vecs[2]  = '{1'b1, 16'h0310, 32'hAABBCCDD, 0, 1, 1'b1, 0, 1};
        vecs[3]  = '{1'b1, 16'h0500, 32'h00000000, 0, 5, 1'b0, 0, 2};
        vecs[4]  = '{1'b1, 16'h0310, 32'hAABBCCDD, 0, 3, 1'b1, 0, 3};
        vecs[5]  = '{1'b0, 16'h03FE, 32'h11223344, 1, 0, 1'b0, 0, 3};
        vecs[6]  = '{1'b1, 16'h03FE, 32'h11223344, 0, 1, 1'b1, 0, 3};
        vecs[7]  = '{1'b0, 16'h0740, 32'h55667788, 0, 0, 1'b0, 4, 4};
        vecs[8]  = '{1'b1, 16'h0740, 32'h55667788, 0, 1, 1'b1, 0, 4};
        vecs[9]  = '{1'b1, 16'h0310, 32'hAABBCCDD, 0, 5, 1'b1, 0, 5};
        vecs[10] = '{1'b1, 16'h0740, 32'h55667788, 0, 3, 1'b1, 0, 6};
        vecs[11] = '{1'b1, 16'h03FE, 32'h11223344, 0, 3, 1'b1, 0, 7};
        vecs[12] = '{1'b0, 16'h0980, 32'h01020304, 0, 0, 1'b0, 2, 8};
        vecs[13] = '{1'b1, 16'h0980, 32'h01020304, 0, 1, 1'b1, 0, 8};

        rst = 1'b1; start_l = 1'b1; re_l = 1'b1; addr = 8'h00;
        tb_data = 8'h00; tb_data_en = 1'b0; tb_dv = 1'b1; tb_dv_en = 1'b0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_miss", 32'(miss), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rd) begin
                do_read(vecs[i].a, lat, got);
                check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
                if (vecs[i].chk_data)
                    check($sformatf("v%0d_data", i), got, vecs[i].d);
            end else begin
                do_write(vecs[i].a, vecs[i].d, vecs[i].gap, drain);
                check($sformatf("v%0d_drain", i), 32'(drain), 32'(vecs[i].exp_drain));
            end
            check($sformatf("v%0d_miss", i), 32'(miss), 32'(vecs[i].exp_miss));
            tick();
        end

        // Start addressed to page 2'b10 must be ignored entirely.
        start_l = 1'b0; re_l = 1'b0; addr = 8'h83;
        tick();
        check("page_busy0", 32'(busy), 32'd0);
        start_l = 1'b1; addr = 8'h10;
        tick();
        check("page_busy1", 32'(busy), 32'd0);
        tick();
        check("page_busy2", 32'(busy), 32'd0);
        check("page_miss", 32'(miss), 32'd8);

        // Reset in the middle of a read burst.
        start_l = 1'b0; re_l = 1'b0; addr = 8'h09;
        tick();
        start_l = 1'b1; addr = 8'h80;
        tick();
        tick();
        check("mid_beat0_valid", 32'(b_dv), 32'd0);
        check("mid_beat0_data", 32'(b_data), 32'h01);
        tick();
        check("mid_beat1_data", 32'(b_data), 32'h02);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_miss", 32'(miss), 32'd0);
        rst = 1'b0;
        tick();

        // Array survives reset: row 3 comes back from the array via a fresh fill.
        do_read(16'h0310, lat, got);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_data", got, 32'hAABBCCDD);
        check("post_rst_miss", 32'(miss), 32'd1);
        tick();
        do_read(16'h03FE, lat, got);
        check("post_rst_wrap_lat", 32'(lat), 32'd1);
        check("post_rst_wrap_data", got, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
